// File: rtl/systolic_mm_core.sv
// systolic_mm_core: NxN output-stationary systolic array computing C = A x B.
// The caller streams N unskewed beats (column k of A with row k of B). The
// core skews them internally, drains the array, then streams out C one row
// at a time. AW must be at least 2*DW.
module systolic_mm_core #(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int AW     = 2*DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  input  logic [N*DW-1:0]      a_col_i,
  input  logic [N*DW-1:0]      b_row_i,
  output logic                 in_ready_o,
  output logic                 res_valid_o,
  input  logic                 out_ready_i,
  output logic [N*AW-1:0]      res_row_o,
  output logic [$clog2(N)-1:0] res_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int IW  = $clog2(N);
  localparam int DCW = $clog2(2*N);
  localparam logic [IW-1:0]  LAST_IDX    = IW'(N-1);
  localparam logic [DCW-1:0] LAST_DRAIN  = DCW'(2*N-2);
  localparam logic           SIGNED_MODE = (SIGNED != 0);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, OUT, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  beat_cnt;
  logic [IW-1:0]  row_idx;
  logic [DCW-1:0] drain_cnt;
  logic           in_ready_q;
  logic           res_valid_q;
  logic           busy_q;
  logic           done_q;

  logic           clear_array;
  logic           advance;

  // Skew line for row i of A / column j of B uses only its first i (or j)
  // stages; stage 0 of each line takes the current beat.
  logic [DW-1:0]  a_src   [N];
  logic [DW-1:0]  b_src   [N];
  logic [DW-1:0]  a_skew  [N][N-1];
  logic [DW-1:0]  b_skew  [N][N-1];
  logic [DW-1:0]  a_feed  [N];
  logic [DW-1:0]  b_feed  [N];
  logic [DW-1:0]  a_pe    [N][N];
  logic [DW-1:0]  b_pe    [N][N];
  logic [DW-1:0]  a_in    [N][N];
  logic [DW-1:0]  b_in    [N][N];
  logic [2*DW-1:0] prod_full [N][N];
  logic [AW-1:0]  prod_ext  [N][N];
  logic [AW-1:0]  acc       [N][N];

  // The array clears when a start is taken, and steps on accepted beats or while draining
  assign clear_array = (state == IDLE) && start_i;
  assign advance     = ((state == LOAD) && in_valid_i) || (state == DRAIN);

  assign in_ready_o  = in_ready_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign res_idx_o   = row_idx;

  // Control FSM: walks IDLE->LOAD->DRAIN->OUT->DONE with registered status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      row_idx     <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            row_idx    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid_i) begin
            if (beat_cnt == LAST_IDX) begin
              state      <= DRAIN;
              beat_cnt   <= '0;
              drain_cnt  <= '0;
              in_ready_q <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state       <= OUT;
            drain_cnt   <= '0;
            row_idx     <= '0;
            res_valid_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        OUT: begin
          if (out_ready_i) begin
            if (row_idx == LAST_IDX) begin
              state       <= DONE;
              row_idx     <= '0;
              res_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              row_idx <= row_idx + IW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // Beat sources (zeros while draining) and the skewed edge feeds into the array
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src[i]  = (state == LOAD) ? a_col_i[i*DW +: DW] : '0;
      b_src[i]  = (state == LOAD) ? b_row_i[i*DW +: DW] : '0;
      a_feed[i] = (i == 0) ? a_src[i] : a_skew[i][(i > 0) ? i - 1 : 0];
      b_feed[i] = (i == 0) ? b_src[i] : b_skew[i][(i > 0) ? i - 1 : 0];
    end
  end

  // PE operands come from the left/upper neighbour; products are full width, then extended
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = (j == 0) ? a_feed[i] : a_pe[i][(j > 0) ? j - 1 : 0];
        b_in[i][j] = (i == 0) ? b_feed[j] : b_pe[(i > 0) ? i - 1 : 0][j];
        prod_full[i][j] = {{DW{SIGNED_MODE & a_in[i][j][DW-1]}}, a_in[i][j]} *
                          {{DW{SIGNED_MODE & b_in[i][j][DW-1]}}, b_in[i][j]};
        prod_ext[i][j] = {AW{SIGNED_MODE & prod_full[i][j][2*DW-1]}};
        prod_ext[i][j][2*DW-1:0] = prod_full[i][j];
      end
    end
  end

  // Array state: skew lines, PE pass-through registers and wrapping accumulators
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N-1; d++) begin
          a_skew[i][d] <= '0;
          b_skew[i][d] <= '0;
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else if (clear_array) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N-1; d++) begin
          a_skew[i][d] <= '0;
          b_skew[i][d] <= '0;
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else if (advance) begin
      for (int i = 0; i < N; i++) begin
        a_skew[i][0] <= a_src[i];
        b_skew[i][0] <= b_src[i];
        for (int d = 1; d < N-1; d++) begin
          a_skew[i][d] <= a_skew[i][d-1];
          b_skew[i][d] <= b_skew[i][d-1];
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[i][j] <= b_in[i][j];
          acc[i][j]  <= acc[i][j] + prod_ext[i][j];
        end
      end
    end
  end

  // Result row r is read straight out of the accumulator grid
  always_comb begin
    res_row_o = '0;
    for (int j = 0; j < N; j++) begin
      res_row_o[j*AW +: AW] = acc[row_idx][j];
    end
  end

endmodule
